// File: rtl/matmul_seq.sv
// Loop sequencer for one D = A*B + C job: walks i/j/k and drives the four-channel
// address generator's load/increment controls plus cycle-aligned datapath qualifiers.
module matmul_seq #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DIM_W      = 11
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic                    stall,
    input  logic [DIM_W-1:0]        rows,
    input  logic [DIM_W-1:0]        cols,
    input  logic [DIM_W-1:0]        inner,
    input  logic [3:0]              stride_cfg,
    input  logic [ADDR_WIDTH+1:0]   a_base,
    input  logic [ADDR_WIDTH+1:0]   b_base,
    input  logic [ADDR_WIDTH+1:0]   c_base,
    input  logic [ADDR_WIDTH+1:0]   d_base,
    output logic [3:0]              add_en,
    output logic [3:0]              clr_en,
    output logic [3:0]              stride,
    output logic [ADDR_WIDTH+1:0]   A_addr_start,
    output logic [ADDR_WIDTH+1:0]   B_addr_start,
    output logic [ADDR_WIDTH+1:0]   C_addr_start,
    output logic [ADDR_WIDTH+1:0]   D_addr_start,
    output logic                    mac_valid,
    output logic                    mac_first,
    output logic                    mac_last,
    output logic                    wb_valid,
    output logic                    busy,
    output logic                    done
);
    localparam int unsigned AW = ADDR_WIDTH + 2;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_WB, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [DIM_W-1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
    logic [DIM_W-1:0]  rows_q, rows_d, cols_q, cols_d, inner_q, inner_d;
    logic [3:0]        stride_q, stride_d;
    logic [AW-1:0]     a_base_q, a_base_d, b_base_q, b_base_d;
    logic [AW-1:0]     a_off_q, a_off_d, b_off_q, b_off_d;
    logic [AW-1:0]     a_st_q, a_st_d, b_st_q, b_st_d, c_st_q, c_st_d, d_st_q, d_st_d;
    logic              first_q, first_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            rows_q   <= '0;
            cols_q   <= '0;
            inner_q  <= '0;
            stride_q <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
            a_off_q  <= '0;
            b_off_q  <= '0;
            a_st_q   <= '0;
            b_st_q   <= '0;
            c_st_q   <= '0;
            d_st_q   <= '0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            rows_q   <= rows_d;
            cols_q   <= cols_d;
            inner_q  <= inner_d;
            stride_q <= stride_d;
            a_base_q <= a_base_d;
            b_base_q <= b_base_d;
            a_off_q  <= a_off_d;
            b_off_q  <= b_off_d;
            a_st_q   <= a_st_d;
            b_st_q   <= b_st_d;
            c_st_q   <= c_st_d;
            d_st_q   <= d_st_d;
            first_q  <= first_d;
        end
    end

    // Next-state and output decode; stall freezes everything and masks the enables
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        inner_d   = inner_q;
        stride_d  = stride_q;
        a_base_d  = a_base_q;
        b_base_d  = b_base_q;
        a_off_d   = a_off_q;
        b_off_d   = b_off_q;
        a_st_d    = a_st_q;
        b_st_d    = b_st_q;
        c_st_d    = c_st_q;
        d_st_d    = d_st_q;
        first_d   = first_q;
        add_en    = 4'b0000;
        clr_en    = 4'b0000;
        mac_valid = 1'b0;
        mac_first = 1'b0;
        mac_last  = 1'b0;
        wb_valid  = 1'b0;
        busy      = (state_q == S_LOAD) || (state_q == S_MAC) || (state_q == S_WB);
        done      = (state_q == S_DONE);

        if (!stall) begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        rows_d   = rows;
                        cols_d   = cols;
                        inner_d  = inner;
                        stride_d = stride_cfg;
                        a_base_d = a_base;
                        b_base_d = b_base;
                        a_off_d  = '0;
                        b_off_d  = '0;
                        i_d      = '0;
                        j_d      = '0;
                        k_d      = '0;
                        if ((rows == '0) || (cols == '0) || (inner == '0)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_LOAD;
                            first_d = 1'b1;
                            a_st_d  = a_base;
                            b_st_d  = b_base;
                            c_st_d  = c_base;
                            d_st_d  = d_base;
                        end
                    end
                end
                S_LOAD: begin
                    clr_en  = first_q ? 4'b1111 : 4'b0011;
                    k_d     = '0;
                    state_d = S_MAC;
                end
                S_MAC: begin
                    add_en    = 4'b0011;
                    mac_valid = 1'b1;
                    mac_first = (k_q == '0);
                    mac_last  = (k_q == inner_q - DIM_W'(1));
                    if (k_q == inner_q - DIM_W'(1)) begin
                        state_d = S_WB;
                    end else begin
                        k_d = k_q + DIM_W'(1);
                    end
                end
                S_WB: begin
                    add_en   = 4'b1100;
                    wb_valid = 1'b1;
                    first_d  = 1'b0;
                    state_d  = S_LOAD;
                    if (j_q == cols_q - DIM_W'(1)) begin
                        j_d     = '0;
                        b_off_d = '0;
                        a_off_d = a_off_q + (AW'(inner_q) << stride_q[0]);
                        if (i_q == rows_q - DIM_W'(1)) begin
                            state_d = S_DONE;
                        end else begin
                            i_d = i_q + DIM_W'(1);
                        end
                    end else begin
                        j_d     = j_q + DIM_W'(1);
                        b_off_d = b_off_q + (AW'(inner_q) << stride_q[1]);
                    end
                    if (state_d == S_LOAD) begin
                        a_st_d = a_base_q + a_off_d;
                        b_st_d = b_base_q + b_off_d;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign stride       = stride_q;
    assign A_addr_start = a_st_q;
    assign B_addr_start = b_st_q;
    assign C_addr_start = c_st_q;
    assign D_addr_start = d_st_q;

endmodule

// File: tb/tb_matmul_seq.sv
// Bench for matmul_seq: per-cycle comparison against an expected event list built
// from the loop nest, plus an address-generator model checking address alignment.
module tb_matmul_seq;
    localparam int unsigned AW = 14;
    localparam int unsigned DW = 11;

    logic          clk = 1'b0, rstn = 1'b0, start = 1'b0, stall = 1'b0;
    logic [DW-1:0] rows = '0, cols = '0, inner = '0;
    logic [3:0]    stride_cfg = '0;
    logic [AW-1:0] a_base = '0, b_base = '0, c_base = '0, d_base = '0;
    logic [3:0]    add_en, clr_en, stride;
    logic [AW-1:0] A_addr_start, B_addr_start, C_addr_start, D_addr_start;
    logic          mac_valid, mac_first, mac_last, wb_valid, busy, done;

    matmul_seq dut (
        .clk(clk), .rstn(rstn), .start(start), .stall(stall),
        .rows(rows), .cols(cols), .inner(inner), .stride_cfg(stride_cfg),
        .a_base(a_base), .b_base(b_base), .c_base(c_base), .d_base(d_base),
        .add_en(add_en), .clr_en(clr_en), .stride(stride),
        .A_addr_start(A_addr_start), .B_addr_start(B_addr_start),
        .C_addr_start(C_addr_start), .D_addr_start(D_addr_start),
        .mac_valid(mac_valid), .mac_first(mac_first), .mac_last(mac_last),
        .wb_valid(wb_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Four-channel address generator driven by the DUT
    logic [AW-1:0] gen [4];
    logic [AW-1:0] gst [4];
    always_comb begin
        gst[0] = A_addr_start;
        gst[1] = B_addr_start;
        gst[2] = C_addr_start;
        gst[3] = D_addr_start;
    end
    always @(posedge clk or negedge rstn) begin
        for (int ch = 0; ch < 4; ch++) begin
            if (!rstn)              gen[ch] <= '0;
            else if (clr_en[ch])    gen[ch] <= gst[ch];
            else if (add_en[ch])    gen[ch] <= gen[ch] + (AW'(1) << stride[ch]);
        end
    end

    typedef struct packed {
        logic [3:0]    add;
        logic [3:0]    clr;
        logic          mv, mf, ml, wv, bz, dn;
        logic          chk_ab, chk_cd;
        logic [AW-1:0] a, b, c, d, ga, gb, gc, gd;
    } exp_t;

    typedef struct {
        int            r, c, n;
        logic [3:0]    s;
        logic [AW-1:0] ab, bb, cb, db;
        int            mode;      // 0 none, 1 scripted stall, 2 restart at cycle 10, 3 random stall
        int            exp_busy;  // -1: derive from dimensions and stalls
    } job_t;

    exp_t q[$];
    int   checks = 0;
    int   bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Expected cycle sequence of a job written directly from the i/j/k loop nest
    function automatic void build(input job_t jb);
        exp_t e;
        q.delete();
        if (jb.r == 0 || jb.c == 0 || jb.n == 0) begin
            e = '0; e.dn = 1'b1; q.push_back(e);
            return;
        end
        for (int i = 0; i < jb.r; i++) begin
            for (int j = 0; j < jb.c; j++) begin
                e = '0; e.bz = 1'b1;
                e.clr = (i == 0 && j == 0) ? 4'hF : 4'h3;
                e.a = AW'(int'(jb.ab) + ((i * jb.n) << jb.s[0]));
                e.b = AW'(int'(jb.bb) + ((j * jb.n) << jb.s[1]));
                e.c = jb.cb; e.d = jb.db;
                q.push_back(e);
                for (int k = 0; k < jb.n; k++) begin
                    e = '0; e.bz = 1'b1; e.add = 4'h3; e.mv = 1'b1;
                    e.mf = (k == 0); e.ml = (k == jb.n - 1); e.chk_ab = 1'b1;
                    e.ga = AW'(int'(jb.ab) + ((i * jb.n) << jb.s[0]) + (k << jb.s[0]));
                    e.gb = AW'(int'(jb.bb) + ((j * jb.n) << jb.s[1]) + (k << jb.s[1]));
                    q.push_back(e);
                end
                e = '0; e.bz = 1'b1; e.add = 4'hC; e.wv = 1'b1; e.chk_cd = 1'b1;
                e.gc = AW'(int'(jb.cb) + ((i * jb.c + j) << jb.s[2]));
                e.gd = AW'(int'(jb.db) + ((i * jb.c + j) << jb.s[3]));
                q.push_back(e);
            end
        end
        e = '0; e.dn = 1'b1; q.push_back(e);
    endfunction

    task automatic run_job(input job_t jb, input int abort_at);
        int   busy_n, stalls, exp_busy;
        bit   wb_st;
        exp_t e;
        build(jb);
        busy_n = 0; stalls = 0; wb_st = 0;
        @(posedge clk); #1;
        rows = DW'(jb.r); cols = DW'(jb.c); inner = DW'(jb.n); stride_cfg = jb.s;
        a_base = jb.ab; b_base = jb.bb; c_base = jb.cb; d_base = jb.db;
        start = 1'b1;
        for (int cyc = 0; cyc < 5000 && q.size() > 0; cyc++) begin
            @(posedge clk); #1;
            start = (jb.mode == 2 && cyc == 10);
            if (cyc == 1 || start) begin
                rows = DW'($urandom_range(7)); cols = DW'($urandom_range(7));
                inner = DW'($urandom_range(7)); stride_cfg = 4'($urandom);
                a_base = AW'($urandom); b_base = AW'($urandom);
                c_base = AW'($urandom); d_base = AW'($urandom);
            end
            stall = 1'b0;
            if (q[0].bz) begin
                if (jb.mode == 1) stall = (cyc >= 2 && cyc <= 4) || (q[0].wv && !wb_st);
                if (jb.mode == 3) stall = ($urandom_range(99) < 20);
            end
            if (stall && q[0].wv) wb_st = 1;
            if (abort_at >= 0 && cyc == abort_at) begin
                stall = 1'b0;
                rstn = 1'b0;
                #1;
                chk("reset_async_ctl", 64'({add_en, clr_en, stride, mac_valid, mac_first,
                    mac_last, wb_valid, busy, done}), 64'(0));
                chk("reset_async_addr", 64'({A_addr_start, B_addr_start, C_addr_start,
                    D_addr_start}), 64'(0));
                repeat (4) begin
                    @(negedge clk);
                    chk("no_done_after_reset", 64'({busy, done}), 64'(0));
                end
                rstn = 1'b1;
                q.delete();
                return;
            end
            @(negedge clk);
            if (busy) busy_n++;
            if (stall) begin
                stalls++;
                chk("stall_gate", 64'({add_en, clr_en, mac_valid, mac_first, mac_last,
                    wb_valid, busy}), 64'(1));
            end else begin
                e = q.pop_front();
                chk("ctl", 64'({add_en, clr_en, mac_valid, mac_first, mac_last, wb_valid,
                    busy, done}), 64'({e.add, e.clr, e.mv, e.mf, e.ml, e.wv, e.bz, e.dn}));
                if (e.clr[0]) chk("ab_start", 64'({A_addr_start, B_addr_start}), 64'({e.a, e.b}));
                if (e.clr[2]) chk("cd_start", 64'({C_addr_start, D_addr_start}), 64'({e.c, e.d}));
                if (e.chk_ab) chk("gen_ab", 64'({gen[0], gen[1]}), 64'({e.ga, e.gb}));
                if (e.chk_cd) chk("gen_cd", 64'({gen[2], gen[3]}), 64'({e.gc, e.gd}));
                if (e.bz) chk("stride", 64'(stride), 64'(jb.s));
            end
        end
        stall = 1'b0;
        if (q.size() > 0) chk("timeout", 64'(q.size()), 64'(0));
        if (jb.exp_busy >= 0) exp_busy = jb.exp_busy;
        else if (jb.r == 0 || jb.c == 0 || jb.n == 0) exp_busy = 0;
        else exp_busy = jb.r * jb.c * (jb.n + 2) + stalls;
        chk("busy_cycles", 64'(busy_n), 64'(exp_busy));
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_after", 64'({busy, done, add_en, clr_en}), 64'(0));
    endtask

    job_t tbl[9];
    job_t jb;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{2, 3, 4, 4'b0000, 14'h0,    14'h0,    14'h0,    14'h0,    0, 36};
        tbl[1] = '{2, 3, 4, 4'b0011, 14'h0,    14'h0,    14'h0,    14'h0,    0, 36};
        tbl[2] = '{2, 3, 4, 4'b0000, 14'h0,    14'h0,    14'h0,    14'h0,    1, 40};
        tbl[3] = '{2, 3, 0, 4'b0000, 14'h0,    14'h0,    14'h0,    14'h0,    0, 0};
        tbl[4] = '{1, 1, 1, 4'b1111, 14'h123,  14'h456,  14'h789,  14'h0AB,  0, 3};
        tbl[5] = '{0, 5, 5, 4'b0101, 14'h10,   14'h20,   14'h30,   14'h40,   0, 0};
        tbl[6] = '{2, 3, 4, 4'b0000, 14'h0,    14'h0,    14'h0,    14'h0,    2, 36};
        tbl[7] = '{3, 2, 5, 4'b1011, 14'h3FF0, 14'h3FFC, 14'h3FFE, 14'h1000, 0, 42};
        tbl[8] = '{4, 1, 3, 4'b0110, 14'h200,  14'h300,  14'h400,  14'h500,  1, -1};

        repeat (3) @(negedge clk);
        chk("reset_state", 64'({add_en, clr_en, stride, mac_valid, mac_first, mac_last,
            wb_valid, busy, done}), 64'(0));
        chk("reset_addr", 64'({A_addr_start, B_addr_start, C_addr_start, D_addr_start}), 64'(0));
        rstn = 1'b1;

        for (int t = 0; t < 9; t++) run_job(tbl[t], -1);

        for (int t = 0; t < 10; t++) begin
            jb = '{int'($urandom_range(4, 1)), int'($urandom_range(4, 1)),
                   int'($urandom_range(5, 1)), 4'($urandom), AW'($urandom), AW'($urandom),
                   AW'($urandom), AW'($urandom), 3, -1};
            run_job(jb, -1);
        end

        run_job(tbl[0], 15);
        run_job(tbl[0], -1);

        $display("test done: total=%0d bad=%0d", checks, bad);
        $finish;
    end
endmodule

// File: doc/matmul_seq.md
# matmul_seq

Loop sequencer that sits directly upstream of the four-channel address generator and drives its `add_en`, `stride`, `clr_en` and `*_addr_start` inputs for one matrix job, D = A·B + C. It walks i < ROWS, j < COLS and k < INNER, reloading the A and B channels for every (i,j) output element. Alongside the address controls it emits datapath qualifiers (`mac_valid`, `mac_first`, `mac_last`, `wb_valid`) that are cycle-aligned to the addresses the generator presents.

## Interface
- ADDR_WIDTH, 12, word-address width; address buses are ADDR_WIDTH+2 bits.
- DIM_W, 11, width of each dimension field.
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start  in  1  job request; sampled only in IDLE
- stall  in  1  freeze; combinationally forces all enables and qualifiers low
- rows, cols, inner  in  DIM_W each  job dimensions; latched on accepted start
- stride_cfg  in  4  per-channel stride; latched on start, drives `stride`
- a_base, b_base, c_base, d_base  in  ADDR_WIDTH+2 each  job base addresses; latched on start
- add_en  out  4  generator increment enables [A,B,C,D = bits 0..3]
- clr_en  out  4  generator load enables
- stride  out  4  latched stride_cfg
- A_addr_start, B_addr_start, C_addr_start, D_addr_start  out  ADDR_WIDTH+2 each  load values
- mac_valid, mac_first, mac_last, wb_valid  out  1 each  datapath qualifiers
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, LOAD, MAC, WB, DONE.
- IDLE, start=1 → LOAD. If any dimension is zero, go to DONE instead, with no enables asserted.
- LOAD (1 cycle):
  - clr_en[1:0]=11.
  - A_addr_start = a_base + a_off; B_addr_start = b_base + b_off.
  - On the first LOAD of a job only, also clr_en[3:2]=11, with C_addr_start = c_base and D_addr_start = d_base.
  - Next state: MAC.
- MAC (INNER cycles, k = 0..INNER-1):
  - add_en[1:0]=11, mac_valid=1.
  - mac_first when k=0; mac_last when k=INNER-1.
  - After k=INNER-1, next state is WB.
- WB (1 cycle):
  - add_en[3:2]=11, wb_valid=1.
  - Then advance j. If j wraps, advance i.
  - Next state is LOAD, or DONE after (ROWS-1, COLS-1).
- DONE (1 cycle): done=1, then IDLE.
- Offsets are held in running accumulators; the block uses no multipliers.
  - b_off += INNER<<stride_cfg[1] per j; it resets to 0 when j wraps.
  - a_off += INNER<<stride_cfg[0] per i.
  - Both are 0 at job start.
  - Arithmetic is mod 2^(ADDR_WIDTH+2); wrap is silent.
- C and D are never reloaded mid-job. They advance only through the WB add_en.
- Outputs not asserted by the current state are 0. *_addr_start hold their last value.
- stall=1: state, counters and offsets all hold. add_en, clr_en, mac_* and wb_valid are 0 in that cycle. busy is unaffected.
- start while busy is ignored. Dimension inputs may change freely after start is accepted.

## Timing
- Reset values:
  - State IDLE; all counters and offsets 0.
  - add_en, clr_en, stride, all *_addr_start, qualifiers, busy and done are all 0.
- Reset asserted mid-job aborts immediately to these values; no done pulse is produced.
- Outputs decode from registered state and counters; the only combinational input path is stall.
- Start sampled at edge e: LOAD occupies the cycle after e, and busy rises in that same cycle.
- Generator alignment: in MAC cycle k, the generator holds base + (k<<stride). In WB, C/D hold base + (i·COLS + j)<<stride.
- Unstalled job length: busy for ROWS·COLS·(INNER+2) cycles, then one cycle of done with busy=0.
- Zero-dimension job: the cycle after start is DONE, with busy=0.
- Back-to-back jobs: start is accepted in the IDLE cycle that follows DONE; minimum gap between jobs is 1 cycle.

## Test plan
- ROWS=2, COLS=3, INNER=4, all bases 0, stride 0:
  - busy is high for exactly 36 cycles, then done for 1 cycle.
  - 24 mac_valid cycles and 6 wb_valid cycles.
  - B_addr_start sequence 0,4,8,0,4,8; A_addr_start sequence 0,0,0,4,4,4.
- Same job with stride_cfg=4'b0011:
  - A_addr_start 0,0,0,8,8,8; B_addr_start 0,8,16,…
  - Generator A address steps by 2 within each MAC burst.
- Inject stall=1 for 3 cycles mid-MAC and 1 cycle in WB:
  - Total busy becomes 40 cycles.
  - Qualifier count is unchanged; no enable is asserted during stall.
- inner=0 with start=1:
  - done pulses in the next cycle.
  - add_en, clr_en and busy stay 0 throughout.
- Pulse start again at busy cycle 10: ignored; the job completes unaltered.
- Deassert rstn at cycle 15 of a 2×3×4 job:
  - All outputs go to 0 asynchronously and no done pulse follows.
  - A new start after release runs a clean 36-cycle job.
